// File: rtl/halt_controller.sv
//------------------------------------------------------------------------------
// halt_controller
//
// Pipeline-control stage that sits directly behind the decode-stage halt
// detector. When an EBREAK is seen in ID it freezes fetch and lets the
// instructions already past ID drain. It then holds the core halted until
// an external resume request arrives, and finally releases the pipeline
// through a one-cycle RESUME state that squashes the stale EBREAK.
//
// Parameters
//   DRAIN_CYCLES : cycles for the halting instruction to retire after it
//                  leaves ID (legal range 1..15)
//   CNT_W        : width of the halted-cycle counter
//
// Ports
//   clk            in   core clock, rising edge
//   rst            in   asynchronous active-low reset
//   halt           in   halt request from the decode-stage detector
//   id_valid       in   ID holds a real instruction
//   flush          in   branch/jump flush of IF/ID this cycle
//   resume_req     in   leave HALTED (sampled only in HALTED)
//   step_req       in   single-step request (needs HALT_SINGLE_STEP_EN)
//   pc_write_en    out  PC load enable (combinational)
//   if_id_write_en out  IF/ID load enable (combinational)
//   id_bubble      out  force a NOP into ID/EX (combinational)
//   halted         out  core fully drained and stopped (registered)
//   resume_ack     out  one-cycle pulse in the RESUME cycle (registered)
//   halt_cycles    out  saturating count of cycles spent in HALTED
//
// Build option
//   HALT_SINGLE_STEP_EN : when defined, step_req in HALTED releases the core
//                         for exactly one instruction, after which it
//                         re-halts. When undefined, step_req is ignored and
//                         no step-pending flop exists.
//------------------------------------------------------------------------------
module halt_controller #(
   parameter int unsigned DRAIN_CYCLES = 3,
   parameter int unsigned CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             halt,
   input  logic             id_valid,
   input  logic             flush,
   input  logic             resume_req,
   input  logic             step_req,
   output logic             pc_write_en,
   output logic             if_id_write_en,
   output logic             id_bubble,
   output logic             halted,
   output logic             resume_ack,
   output logic [CNT_W-1:0] halt_cycles
);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2,
      ST_RESUME = 2'd3
   } state_t;

   // The drain counter starts at DRAIN_CYCLES-1 so DRAIN lasts exactly
   // DRAIN_CYCLES cycles (the state is left when the counter reads 0).
   localparam logic [3:0]       DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   state_t           state_r;
   state_t           state_next_s;
   logic [3:0]       drain_cnt_r;
   logic [CNT_W-1:0] halt_cycles_r;
   logic             halted_r;
   logic             resume_ack_r;
   logic             halt_event_s;
   logic             step_go_s;
   logic             step_trigger_s;

`ifdef HALT_SINGLE_STEP_EN
   logic step_pending_r;

   // A step only counts when no plain resume is requested alongside it.
   assign step_go_s      = step_req & ~resume_req;
   // While a step is pending, the first real, unflushed instruction in ID
   // is treated exactly like an EBREAK.
   assign step_trigger_s = step_pending_r & id_valid & ~flush;

   // Step-pending flag: set when a step releases HALTED, cleared by the
   // halt event that the stepped instruction produces.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         step_pending_r <= 1'b0;
      end else if ((state_r == ST_HALTED) && step_go_s) begin
         step_pending_r <= 1'b1;
      end else if (halt_event_s) begin
         step_pending_r <= 1'b0;
      end else begin
         step_pending_r <= step_pending_r;
      end
   end
`else
   logic unused_step_s;

   assign unused_step_s  = step_req;
   assign step_go_s      = 1'b0;
   assign step_trigger_s = 1'b0;
`endif

   // A halt only counts in RUN; halts during a flush or with an empty ID
   // slot are spurious and must not freeze the pipeline.
   assign halt_event_s = (state_r == ST_RUN) & id_valid & ~flush
                       & (halt | step_trigger_s);

   // Next-state selection for the halt/drain/resume sequence.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_RUN: begin
            if (halt_event_s) begin
               state_next_s = ST_DRAIN;
            end else begin
               state_next_s = ST_RUN;
            end
         end
         ST_DRAIN: begin
            // halt is deliberately not looked at here: the stale EBREAK is
            // still sitting in IF/ID and keeps the detector asserted.
            if (drain_cnt_r == 4'd0) begin
               state_next_s = ST_HALTED;
            end else begin
               state_next_s = ST_DRAIN;
            end
         end
         ST_HALTED: begin
            if (resume_req || step_go_s) begin
               state_next_s = ST_RESUME;
            end else begin
               state_next_s = ST_HALTED;
            end
         end
         ST_RESUME: begin
            state_next_s = ST_RUN;
         end
         default: begin
            state_next_s = ST_RUN;
         end
      endcase
   end

   // State register plus the registered halted/resume_ack flags, which are
   // derived from the next state so they line up with the state they flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r      <= ST_RUN;
         halted_r     <= 1'b0;
         resume_ack_r <= 1'b0;
      end else begin
         state_r      <= state_next_s;
         halted_r     <= (state_next_s == ST_HALTED);
         resume_ack_r <= (state_next_s == ST_RESUME);
      end
   end

   // Drain counter: loaded on the halt event, counts down through DRAIN.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         drain_cnt_r <= 4'd0;
      end else if (halt_event_s) begin
         drain_cnt_r <= DRAIN_LOAD;
      end else if ((state_r == ST_DRAIN) && (drain_cnt_r != 4'd0)) begin
         drain_cnt_r <= drain_cnt_r - 4'd1;
      end else begin
         drain_cnt_r <= drain_cnt_r;
      end
   end

   // Halted-cycle counter: one count per HALTED cycle, sticks at all-ones.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         halt_cycles_r <= {CNT_W{1'b0}};
      end else if ((state_r == ST_HALTED) && (halt_cycles_r != CNT_MAX)) begin
         halt_cycles_r <= halt_cycles_r + CNT_ONE;
      end else begin
         halt_cycles_r <= halt_cycles_r;
      end
   end

   // Pipeline enables. In RUN the write enables drop in the very cycle of
   // the halt event so the PC stops at EBREAK+4; the bubble stays low so
   // the halting instruction itself still moves on into EX.
   always_comb begin
      pc_write_en    = 1'b1;
      if_id_write_en = 1'b1;
      id_bubble      = 1'b0;
      case (state_r)
         ST_RUN: begin
            pc_write_en    = ~halt_event_s;
            if_id_write_en = ~halt_event_s;
            id_bubble      = 1'b0;
         end
         ST_DRAIN, ST_HALTED: begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            id_bubble      = 1'b1;
         end
         ST_RESUME: begin
            // IF/ID loads the instruction at EBREAK+4 while the bubble
            // squashes the stale EBREAK on its way to EX.
            pc_write_en    = 1'b1;
            if_id_write_en = 1'b1;
            id_bubble      = 1'b1;
         end
         default: begin
            pc_write_en    = 1'b1;
            if_id_write_en = 1'b1;
            id_bubble      = 1'b0;
         end
      endcase
   end

   assign halted      = halted_r;
   assign resume_ack  = resume_ack_r;
   assign halt_cycles = halt_cycles_r;

endmodule

// File: tb/tb_halt_controller.sv
//------------------------------------------------------------------------------
// tb_halt_controller
//
// Self-checking bench for halt_controller. The reference model describes the
// expected behaviour as a timeline: the cycle a halt was accepted and the
// cycle a resume was accepted. From those, each cycle's phase (running,
// draining, halted, resuming) follows from plain arithmetic. CNT_W is reduced
// to 4 so counter saturation is reachable.
//------------------------------------------------------------------------------
module tb_halt_controller;

   localparam int D      = 3;
   localparam int CW     = 4;
   localparam int HC_MAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          halt = 1'b0;
   logic          id_valid = 1'b0;
   logic          flush = 1'b0;
   logic          resume_req = 1'b0;
   logic          step_req = 1'b0;
   logic          pc_write_en;
   logic          if_id_write_en;
   logic          id_bubble;
   logic          halted;
   logic          resume_ack;
   logic [CW-1:0] halt_cycles;

   int checks = 0;
   int errors = 0;

   // reference model state
   int   cyc = 0;
   int   halt_at = -1;
   int   resume_at = -1;
   int   hc = 0;
   bit   step_pend = 1'b0;
   logic [4:0] exp_vec;

   halt_controller #(.DRAIN_CYCLES(D), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .halt(halt), .id_valid(id_valid), .flush(flush),
      .resume_req(resume_req), .step_req(step_req),
      .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en),
      .id_bubble(id_bubble), .halted(halted), .resume_ack(resume_ack),
      .halt_cycles(halt_cycles)
   );

   always #5 clk = ~clk;

   // 0 run, 1 drain, 2 halted, 3 resume
   function automatic int phase();
      if (resume_at >= 0 && cyc == resume_at + 1) return 3;
      if (halt_at >= 0 && cyc > halt_at + D) return 2;
      if (halt_at >= 0 && cyc > halt_at) return 1;
      return 0;
   endfunction

   function automatic bit halt_accepted();
      return (phase() == 0) && id_valid && !flush && (halt || step_pend);
   endfunction

   function automatic logic [4:0] expected_outputs();
      bit ev;
      ev = halt_accepted();
      case (phase())
         0: return {~ev, ~ev, 1'b0, 1'b0, 1'b0};
         1: return 5'b00100;
         2: return 5'b00110;
         default: return 5'b11101;
      endcase
   endfunction

   task automatic model_reset();
      halt_at = -1; resume_at = -1; hc = 0; step_pend = 1'b0;
   endtask

   // wait for the sampling point and compute what the outputs must be
   task automatic sample();
      @(negedge clk);
      exp_vec = expected_outputs();
   endtask

   // apply this cycle's inputs to the model, then move to the next cycle
   task automatic advance();
      int p;
      p = phase();
      if (p == 0 && halt_accepted()) begin
         halt_at = cyc; step_pend = 1'b0;
      end
      if (p == 2) begin
         if (hc < HC_MAX) hc++;
         if (resume_req) begin
            resume_at = cyc; halt_at = -1; step_pend = 1'b0;
         end
`ifdef HALT_SINGLE_STEP_EN
         else if (step_req) begin
            resume_at = cyc; halt_at = -1; step_pend = 1'b1;
         end
`endif
      end
      if (p == 3) resume_at = -1;
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if ({pc_write_en, if_id_write_en, id_bubble, halted, resume_ack, halt_cycles} !== {5'b11000, 4'd0}) begin
         errors++;
         $display("FAIL reset_values: got %b/%0d required 11000/0",
                  {pc_write_en, if_id_write_en, id_bubble, halted, resume_ack}, halt_cycles);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      model_reset();
   endtask

   task automatic test_ebreak_halt();
      for (int i = 0; i < 20; i++) begin
         id_valid = 1'b1; flush = 1'b0;
         halt = (i == 3); resume_req = (i == 13);
         sample();
         checks++;
         if ({pc_write_en, if_id_write_en, id_bubble, halted, resume_ack} !== exp_vec) begin
            errors++;
            $display("FAIL ebreak_outputs step %0d: got %b required %b", i,
                     {pc_write_en, if_id_write_en, id_bubble, halted, resume_ack}, exp_vec);
         end
         checks++;
         if (halt_cycles !== CW'(hc)) begin
            errors++;
            $display("FAIL ebreak_count step %0d: got %0d required %0d", i, halt_cycles, hc);
         end
         if (i == 3 || i == 7 || i == 14 || i == 15) begin
            checks++;
            if ((i == 3 && pc_write_en !== 1'b0) || (i == 7 && halted !== 1'b1) ||
                (i == 14 && (resume_ack !== 1'b1 || halt_cycles !== 4'd7)) ||
                (i == 15 && halted !== 1'b0)) begin
               errors++;
               $display("FAIL ebreak_timeline step %0d: got pc_we=%b halted=%b ack=%b hc=%0d",
                        i, pc_write_en, halted, resume_ack, halt_cycles);
            end
         end
         advance();
      end
   endtask

   task automatic test_ignored_halt();
      for (int i = 0; i < 6; i++) begin
         halt = 1'b1; resume_req = 1'b0;
         flush = i[0]; id_valid = i[0];
         sample();
         checks++;
         if ({pc_write_en, if_id_write_en, id_bubble, halted, resume_ack} !== 5'b11000 ||
             {pc_write_en, if_id_write_en, id_bubble, halted, resume_ack} !== exp_vec) begin
            errors++;
            $display("FAIL ignored_halt step %0d: got %b required %b", i,
                     {pc_write_en, if_id_write_en, id_bubble, halted, resume_ack}, exp_vec);
         end
         advance();
      end
      halt = 1'b0; flush = 1'b0;
   endtask

   task automatic test_resume_outside_halted();
      for (int i = 0; i < 14; i++) begin
         id_valid = 1'b1; halt = (i == 0);
         resume_req = (i == 0 || i == 2 || i == 9);
         sample();
         checks++;
         if ({pc_write_en, if_id_write_en, id_bubble, halted, resume_ack} !== exp_vec) begin
            errors++;
            $display("FAIL resume_outside step %0d: got %b required %b", i,
                     {pc_write_en, if_id_write_en, id_bubble, halted, resume_ack}, exp_vec);
         end
         if (i == 8) begin
            checks++;
            if (halted !== 1'b1) begin
               errors++;
               $display("FAIL resume_not_latched: halted got %b required 1", halted);
            end
         end
         advance();
      end
   endtask

   task automatic test_reset_mid_drain();
      for (int i = 0; i < 3; i++) begin
         id_valid = 1'b1; halt = (i == 0); resume_req = 1'b0;
         sample();
         checks++;
         if ({pc_write_en, if_id_write_en, id_bubble, halted, resume_ack} !== exp_vec) begin
            errors++;
            $display("FAIL pre_reset step %0d: got %b required %b", i,
                     {pc_write_en, if_id_write_en, id_bubble, halted, resume_ack}, exp_vec);
         end
         if (i < 2) advance();
      end
      // mid-DRAIN, away from any clock edge
      halt = 1'b0; id_valid = 1'b0;
      #2 rst = 1'b0;
      #1;
      model_reset();
      checks++;
      if ({pc_write_en, if_id_write_en, id_bubble, halted, resume_ack, halt_cycles} !== {5'b11000, 4'd0}) begin
         errors++;
         $display("FAIL async_reset: got %b/%0d required 11000/0",
                  {pc_write_en, if_id_write_en, id_bubble, halted, resume_ack}, halt_cycles);
      end
      advance();
      rst = 1'b1;
   endtask

   task automatic test_step();
      for (int i = 0; i < 24; i++) begin
         id_valid = 1'b1; flush = (i == 11); halt = (i == 0);
         resume_req = (i == 19);
         step_req = (i == 6 || i == 19);
         sample();
         checks++;
         if ({pc_write_en, if_id_write_en, id_bubble, halted, resume_ack} !== exp_vec) begin
            errors++;
            $display("FAIL step step %0d: got %b required %b", i,
                     {pc_write_en, if_id_write_en, id_bubble, halted, resume_ack}, exp_vec);
         end
         if (i == 13) begin
            checks++;
`ifdef HALT_SINGLE_STEP_EN
            // step at 6, RESUME 7, flushed slot at 8? no: RUN at 8, halt event 8, halted at 12
            if (halted !== 1'b1 || resume_ack !== 1'b0) begin
`else
            if (halted !== 1'b1) begin
`endif
               errors++;
               $display("FAIL step_rehalt: halted got %b ack got %b", halted, resume_ack);
            end
         end
         advance();
      end
      step_req = 1'b0; resume_req = 1'b0; flush = 1'b0;
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 28; i++) begin
         id_valid = 1'b1; halt = (i == 0); resume_req = (i == 25);
         sample();
         checks++;
         if (halt_cycles !== CW'(hc)) begin
            errors++;
            $display("FAIL saturation step %0d: got %0d required %0d", i, halt_cycles, hc);
         end
         if (i == 25) begin
            checks++;
            if (halt_cycles !== 4'hF) begin
               errors++;
               $display("FAIL saturation_max: got %0d required 15", halt_cycles);
            end
         end
         advance();
      end
      resume_req = 1'b0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 1500; i++) begin
         halt       = ($urandom_range(7) == 0);
         id_valid   = ($urandom_range(3) != 0);
         flush      = ($urandom_range(7) == 0);
         resume_req = ($urandom_range(9) == 0);
         step_req   = ($urandom_range(9) == 0);
         sample();
         checks++;
         if ({pc_write_en, if_id_write_en, id_bubble, halted, resume_ack} !== exp_vec) begin
            errors++;
            $display("FAIL random_outputs cyc %0d: got %b required %b", cyc,
                     {pc_write_en, if_id_write_en, id_bubble, halted, resume_ack}, exp_vec);
         end
         checks++;
         if (halt_cycles !== CW'(hc)) begin
            errors++;
            $display("FAIL random_count cyc %0d: got %0d required %0d", cyc, halt_cycles, hc);
         end
         advance();
      end
   endtask

   initial begin
      test_reset();
      test_ebreak_halt();
      test_ignored_halt();
      test_resume_outside_halted();
      test_reset_mid_drain();
      test_step();
      test_saturation();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/halt_controller.md
# halt_controller

Sequential pipeline-control stage directly downstream of the decode-stage halt detector. It consumes the combinational `halt` flag raised when an EBREAK sits in ID and freezes instruction fetch. It then drains the instructions already past ID and holds the core in a halted state until an external resume request. It drives the PC and IF/ID write enables and the ID/EX bubble select.

## Interface
- `DRAIN_CYCLES`, 3: cycles for the halting instruction to retire after leaving ID (EX, MEM, WB); legal range 1–15.
- `CNT_W`, 32: width of the halted-cycle counter.

- `clk` in 1: core clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `halt` in 1: halt request from the decode-stage halt detector (combinational, same cycle as the instruction in ID).
- `id_valid` in 1: the ID stage holds a real instruction.
- `flush` in 1: branch/jump flush of IF/ID this cycle.
- `resume_req` in 1: request to leave the halted state; sampled only in HALTED.
- `step_req` in 1: single-step request; functional only with `HALT_SINGLE_STEP_EN`.
- `pc_write_en` out 1: PC register load enable.
- `if_id_write_en` out 1: IF/ID register load enable.
- `id_bubble` out 1: forces a NOP into ID/EX.
- `halted` out 1: core fully drained and stopped.
- `resume_ack` out 1: one-cycle pulse when leaving HALTED.
- `halt_cycles` out CNT_W: count of cycles spent in HALTED since reset.

## Operation
- States: RUN, DRAIN, HALTED, RESUME.
- Halt event: `halt & id_valid & ~flush` in RUN. A halt raised during a flush or with `id_valid`=0 is ignored.
- RUN:
  - Outputs: `pc_write_en`=1, `if_id_write_en`=1, `id_bubble`=0.
  - On a halt event, both write enables drop to 0 combinationally in the same cycle. `id_bubble` stays 0 so the halting instruction advances to EX.
  - On a halt event, go to DRAIN and load the drain counter with DRAIN_CYCLES−1.
- DRAIN:
  - Outputs: `pc_write_en`=0, `if_id_write_en`=0, `id_bubble`=1.
  - The counter decrements each cycle; at 0, go to HALTED.
  - `halt` is ignored because the stale EBREAK remains in IF/ID.
- HALTED:
  - Outputs: same as DRAIN, plus `halted`=1.
  - `halt_cycles` increments each cycle, saturating at all-ones.
  - `resume_req`=1 takes the state to RESUME.
- RESUME (one cycle):
  - Outputs: `pc_write_en`=1, `if_id_write_en`=1, `id_bubble`=1, `resume_ack`=1.
  - The PC already holds EBREAK+4, so IF/ID loads the next instruction and the stale EBREAK is squashed.
  - Next state is RUN.
- `resume_req`/`step_req` outside HALTED: ignored, not latched.
- `resume_req` and `step_req` both high in HALTED: the plain resume wins.
- Reset (any state, including mid-DRAIN): RUN, counters 0, `halted`=0, `resume_ack`=0, `pc_write_en`=1, `if_id_write_en`=1, `id_bubble`=0, `halt_cycles`=0.

## Timing
- Halting instruction in ID at cycle T.
  - T: write enables low.
  - T+1..T+DRAIN_CYCLES: DRAIN.
  - T+DRAIN_CYCLES+1: `halted`=1 (registered).
- `resume_req` high at cycle H in HALTED.
  - H+1: RESUME with `resume_ack`=1.
  - H+2: RUN, `halted`=0.
- Latency from `resume_req` to the first new instruction in ID: 2 cycles.
- The state register, drain counter, step flag, and `halt_cycles` are updated on `posedge clk` or `negedge rst`. Enables are combinational from state and inputs.

## Configuration
- `HALT_SINGLE_STEP_EN` defined:
  - `step_req` in HALTED enters RESUME and sets `step_pending`.
  - In RUN with `step_pending`=1, the first cycle with `id_valid & ~flush` is treated as a halt event, and `step_pending` clears.
  - That instruction proceeds to EX and drains, then the core re-halts.
  - A real EBREAK in that slot behaves identically.
- Macro undefined: `step_req` is ignored, and no `step_pending` flop is synthesized.

## Test plan
- EBREAK in ID at cycle 10, DRAIN_CYCLES=3 -> enables low at 10; `id_bubble` high at 11–13; `halted` rises at 14; PC unchanged from 14 onward.
- Halted at 14, `resume_req` pulse at 20 -> `resume_ack`=1 at 21, `halted`=0 at 22, IF/ID loads EBREAK+4 at the 21 edge; `halt_cycles`=7.
- `halt`=1 with `flush`=1, and separately `halt`=1 with `id_valid`=0 -> no state change; enables stay 1.
- `rst` asserted at cycle 12 of the first scenario (mid-DRAIN) -> immediate RUN; all outputs return to their reset values asynchronously.
- `resume_req` while in RUN or DRAIN -> ignored; a later resume is still required once HALTED.
- With `HALT_SINGLE_STEP_EN`, `step_req` in HALTED -> RESUME, one instruction issued to EX, re-halted DRAIN_CYCLES+1 cycles after it is in ID. Without the macro -> no response to `step_req`.
